// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one ack-based memory bus between instruction fetch and data access.
// Data wins ties; stall_pipl holds the pipeline until every pending requester is served.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_sel_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_valid_o,
    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    input  logic                bus_err_i,
    output logic                stall_pipl,
    output logic                bus_fault_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

    state_t      state, state_nxt;
    logic        if_done, dm_done;
    logic [9:0]  tcnt;
    logic        if_pend, dm_pend;
    logic        timeout, complete, fail;

    assign if_pend    = if_req_i & ~if_done;
    assign dm_pend    = dm_req_i & ~dm_done;
    assign stall_pipl = if_pend | dm_pend;
    assign bus_stb_o  = bus_cyc_o;

    // tcnt == TO_LAST marks the TIMEOUT_CYC-th cycle spent waiting on the slave
    assign timeout  = (tcnt == TO_LAST);
    assign complete = (state != IDLE) & (bus_ack_i | bus_err_i | timeout);
    assign fail     = bus_err_i | timeout;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_pend)      state_nxt = DATA;
                else if (if_pend) state_nxt = INSTR;
            end
            DATA, INSTR: begin
                if (complete) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
            tcnt        <= '0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_valid_o  <= 1'b0;
            dm_valid_o  <= 1'b0;
            bus_fault_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            if_valid_o  <= 1'b0;
            dm_valid_o  <= 1'b0;
            bus_fault_o <= 1'b0;
            // pipeline advanced: forget what was served; a completion below overrides
            if (!stall_pipl) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (dm_pend) begin
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= dm_we_i;
                        bus_sel_o   <= dm_sel_i;
                        bus_addr_o  <= dm_addr_i;
                        bus_wdata_o <= dm_wdata_i;
                    end else if (if_pend) begin
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= {SEL_W{1'b1}};
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                default: begin
                    if (complete) begin
                        bus_cyc_o   <= 1'b0;
                        bus_fault_o <= fail;
                        if (state == DATA) begin
                            dm_valid_o <= 1'b1;
                            dm_done    <= 1'b1;
                            dm_rdata_o <= fail ? '0 : bus_rdata_i;
                        end else begin
                            if_valid_o <= 1'b1;
                            if_done    <= 1'b1;
                            if_rdata_o <= fail ? '0 : bus_rdata_i;
                        end
                    end else begin
                        tcnt <= tcnt + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-port, ack-based memory bus between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage).
- Sequences at most one bus transaction at a time.
- Generates the pipeline-freeze signal consumed by the pipeline controller as stall_pipl.
- Sits between the core pipeline and the SoC memory/peripheral interconnect.

Parameters:
- ADDR_W, 32, address width of both requesters and the bus.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- TIMEOUT_CYC, 255, cycles without bus_ack_i/bus_err_i before a transaction is force-terminated (range 1..1023).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held by IF until the pipeline advances.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  registered fetch data.
- if_valid_o  out  1  one-cycle pulse: fetch completed.
- dm_req_i  in  1  data request; held by MEM until the pipeline advances.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_sel_i  in  DATA_W/8  byte enables.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  registered load data.
- dm_valid_o  out  1  one-cycle pulse: data access completed.
- bus_cyc_o, bus_stb_o  out  1  bus cycle and strobe; always equal to each other.
- bus_we_o  out  1  bus write enable.
- bus_sel_o  out  DATA_W/8  bus byte select.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data, valid when ack is high.
- bus_ack_i  in  1  transaction complete.
- bus_err_i  in  1  transaction complete with error.
- stall_pipl  out  1  freeze the pipeline.
- bus_fault_o  out  1  one-cycle pulse on bus error or timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; if_done and dm_done cleared; timeout counter 0.
  - Reset asserted mid-transaction drops bus_cyc_o/bus_stb_o at that edge; no valid pulse is produced.
- FSM states: IDLE, DATA, INSTR.
- IDLE transitions:
  - dm_req_i & ~dm_done → DATA.
  - else if_req_i & ~if_done → INSTR.
  - Data has priority because the MEM stage holds the older instruction.
  - Bus outputs are registered from the granted requester at the transition edge, so cyc/stb rise the cycle after the request is seen.
- Bus outputs during an access:
  - bus_we_o and bus_sel_o are 0 and all-ones respectively in INSTR.
  - Address, data and control are held stable while in DATA/INSTR.
- Completion (in DATA/INSTR, on bus_ack_i | bus_err_i | timeout):
  - Drop cyc/stb at the edge.
  - Capture bus_rdata_i into the matching rdata register, or 0 on error/timeout.
  - Pulse the matching valid for exactly one cycle.
  - Set the matching done flag; return to IDLE.
  - Ack and err high together is treated as err.
- Timeout:
  - Counter resets on entry to DATA/INSTR and increments each waiting cycle.
  - Reaching TIMEOUT_CYC counts as completion with error.
- bus_fault_o pulses concurrently with the valid of an erroring or timed-out access.
- Stores: dm_rdata_o is updated with bus_rdata_i anyway; the value is don't-care to the MEM stage.
- Latency: request seen in cycle N, zero-wait slave acks in N+1, valid and data presented in N+2. Minimum two cycles per access; no back-to-back bus cycles.
- stall_pipl is combinational: (if_req_i & ~if_done) | (dm_req_i & ~dm_done).
- Done flags clear on any edge where stall_pipl is 0, i.e. when the pipeline advances. A served requester is therefore not re-issued while the other is still pending.
- Simultaneous requests: DATA is served first, then INSTR. stall_pipl stays high until both are done.
- A request dropping while in IDLE (e.g. flush) is simply not served. A request dropping mid-transaction does not abort it; the valid pulse is still emitted and ignored.
- rdata registers hold their value until the next completion for the same requester.

Test Plan:
- Fetch only, zero-wait slave acking in the cycle after stb, addr 0x100, data 0x00500093 → cyc high 1 cycle; if_valid_o pulse at N+2 with if_rdata_o 0x00500093; stall_pipl high cycles N..N+1, low at N+2.
- Simultaneous fetch 0x104 and load 0x2000 (slave returns 0xDEADBEEF) → bus_addr_o 0x2000 first, then 0x104; stall_pipl high until the second valid; dm_valid_o precedes if_valid_o by 2 cycles.
- Store with dm_sel_i 0b0011, wdata 0x1234ABCD, 3 wait states → bus_we_o=1, sel=0b0011, wdata stable for 4 cycles; single dm_valid_o pulse.
- No ack, TIMEOUT_CYC=8 → forced completion after 8 wait cycles; dm_rdata_o=0; bus_fault_o and dm_valid_o pulse together; stall_pipl then drops.
- bus_err_i during fetch → if_rdata_o=0, bus_fault_o pulse, return to IDLE; held request is not re-issued after done.
- reset asserted for one cycle mid-transaction → cyc/stb low next cycle, no valid pulse, stall_pipl recomputed with done flags 0; request re-issued after reset deasserts.
